// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the iterative divider.
//   state_t : FSM states of div_unit (IDLE, CALC, FINISH)
//   op_t    : decoded operation (DIV, DIVU, REM, REMU)
//   DEFAULT_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } op_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in       : partial remainder before the step (always < divisor)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit and trial-subtract. Because rem_in is
    // kept below the divisor, the shifted value is below twice the divisor,
    // so the top bit of the difference alone tells whether the subtraction
    // went negative (restore) or not (keep the difference, quotient bit 1).
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative restoring divider for signed/unsigned quotient and remainder.
// One quotient bit per cycle; result valid WIDTH+2 cycles after start.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : request a new operation (sampled while busy=0)
//   sel_div/divu/rem/remu : one-hot operation select (priority div>divu>rem>remu)
//   operand_a, operand_b: dividend, divisor
//   busy                : operation in progress
//   done                : one-cycle pulse, result valid
//   result              : quotient or remainder, held until the next done
//
// Configuration macro
//   DIV_SPECIAL_FASTPATH_EN : divide-by-zero and signed overflow skip the
//                             iterative phase and finish 2 cycles after start.
// -----------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel_div,
    input  logic             sel_divu,
    input  logic             sel_rem,
    input  logic             sel_remu,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    op_t              op;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] dividend_orig;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             sgn_ovf;

    logic             sel_any;
    op_t              next_op;
    logic             cap_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             cap_zero;
    logic             cap_ovf;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    logic             is_quot;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] final_result;

    // Decode the requested operation and prepare operand magnitudes, sign
    // flags and special-case flags so they can be captured on the start edge.
    always_comb begin
        sel_any = sel_div | sel_divu | sel_rem | sel_remu;
        next_op = DIV;
        if (sel_div)
            next_op = DIV;
        else if (sel_divu)
            next_op = DIVU;
        else if (sel_rem)
            next_op = REM;
        else if (sel_remu)
            next_op = REMU;

        cap_signed = (next_op == DIV) || (next_op == REM);
        a_neg      = cap_signed & operand_a[WIDTH-1];
        b_neg      = cap_signed & operand_b[WIDTH-1];
        a_mag      = a_neg ? -operand_a : operand_a;
        b_mag      = b_neg ? -operand_b : operand_b;
        cap_zero   = (operand_b == '0);
        cap_ovf    = cap_signed && (operand_a == MIN_NEG) && (operand_b == '1);
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in       (rem_reg),
        .dividend_bit (quo_reg[WIDTH-1]),
        .divisor      (divisor_reg),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Sign correction and special-case override of the raw magnitudes.
    // Divide-by-zero and signed overflow are forced explicitly so the
    // fast path (which never iterates) yields the same values.
    always_comb begin
        is_quot = (op == DIV) || (op == DIVU);
        q_fix   = neg_q ? -quo_reg : quo_reg;
        r_fix   = neg_r ? -rem_reg : rem_reg;
        if (div_zero)
            final_result = is_quot ? '1 : dividend_orig;
        else if (sgn_ovf)
            final_result = is_quot ? MIN_NEG : '0;
        else
            final_result = is_quot ? q_fix : r_fix;
    end

    // Control FSM and datapath registers. quo_reg starts as the dividend
    // magnitude and is shifted left each step, so its MSB feeds the step and
    // the new quotient bit enters at the LSB; after WIDTH steps it holds the
    // quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op            <= DIV;
            count         <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            dividend_orig <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
            sgn_ovf       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && sel_any) begin
                        op            <= next_op;
                        quo_reg       <= a_mag;
                        rem_reg       <= '0;
                        divisor_reg   <= b_mag;
                        dividend_orig <= operand_a;
                        neg_q         <= a_neg ^ b_neg;
                        neg_r         <= a_neg;
                        div_zero      <= cap_zero;
                        sgn_ovf       <= cap_ovf;
                        count         <= CNT_INIT;
                        busy          <= 1'b1;
`ifdef DIV_SPECIAL_FASTPATH_EN
                        state         <= (cap_zero || cap_ovf) ? FINISH : CALC;
`else
                        state         <= CALC;
`endif
                    end
                end
                CALC: begin
                    quo_reg <= {quo_reg[WIDTH-2:0], step_q};
                    rem_reg <= step_rem;
                    count   <= count - CNT_LAST;
                    if (count == CNT_LAST)
                        state <= FINISH;
                end
                FINISH: begin
                    result <= final_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation, sampled only while busy=0.
REQ-005 SHALL have ports sel_div, sel_divu, sel_rem and sel_remu, each input, 1 bit: one-hot operation select, sampled with start.
REQ-006 SHALL have ports operand_a (dividend) and operand_b (divisor), each input, WIDTH bits, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 SHALL have port done, output, 1 bit: registered one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, WIDTH bits: quotient or remainder, held until the next done.

Function
REQ-010 SHALL implement a state machine with states IDLE, CALC and FINISH.
REQ-011 IDLE with start=1 and at least one select high SHALL capture operands and operation, set busy, and go to CALC.
REQ-012 Start with no select high SHALL be ignored; with several selects high, priority SHALL be div > divu > rem > remu.
REQ-013 Start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-014 CALC SHALL perform one restoring-division step per cycle on operand magnitudes for exactly WIDTH cycles (down-counter), then go to FINISH.
REQ-015 DIV/REM SHALL take absolute values of the operands at capture; DIVU/REMU SHALL use the operands unmodified.
REQ-016 FINISH SHALL apply sign correction: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-017 FINISH SHALL register result, pulse done for the following cycle, clear busy, and return to IDLE.
REQ-018 Latency SHALL be WIDTH+2 cycles from the start edge to the done cycle (34 at WIDTH=32).
REQ-019 A start in the done cycle SHALL be accepted, giving back-to-back operation.
REQ-020 Divisor 0 SHALL give quotient all-ones for DIV/DIVU and remainder = operand_a for REM/REMU.
REQ-021 DIV of the most-negative value by -1 SHALL give the most-negative value; REM of the same operands SHALL give 0.
REQ-022 Wrap-around SHALL be modulo 2^WIDTH; no overflow or exception output.

Reset
REQ-023 rst SHALL force state IDLE, busy=0, done=0 and result=0, and clear the counter and working registers.
REQ-024 rst during CALC or FINISH SHALL abort the operation with no done pulse; the first cycle after reset SHALL accept start.

Configuration
REQ-025 SHALL support macro DIV_SPECIAL_FASTPATH_EN.
REQ-026 With DIV_SPECIAL_FASTPATH_EN defined, divisor-0 and signed-overflow cases SHALL go IDLE to FINISH directly, with done 2 cycles after the start edge.
REQ-027 Without DIV_SPECIAL_FASTPATH_EN, these cases SHALL run the full WIDTH+2 latency; results SHALL be identical per REQ-020 and REQ-021.

Structure
REQ-028 Package div_pkg SHALL hold the state enum (IDLE/CALC/FINISH), the operation enum (DIV/DIVU/REM/REMU) and the default WIDTH constant.
REQ-029 Sub-module div_step SHALL be combinational and implement one restoring step: shift the partial remainder, trial-subtract, and emit a quotient bit.
REQ-030 Sign correction and special-case detection SHALL reside in div_unit.

Verification
REQ-031 DIVU 100/7 then REMU 100/7 -> 0x0000000E then 0x00000002; done exactly 34 cycles after each start; busy high in between.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 0x00000001.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; done at 2 cycles with DIV_SPECIAL_FASTPATH_EN, at 34 without.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
REQ-035 rst at cycle 10 of a DIVU -> busy 0, result 0, no done; a new DIVU 9/3 started the next cycle -> 0x00000003 after 34 cycles.
REQ-036 start pulses during busy -> ignored, result unchanged; start in the done cycle -> accepted, second done 34 cycles later.
